puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Initiator side of the ring-oscillator PUF measurement path: issues challenges and the oscillator enable to the CRO, and consumes its output.
- For each response bit it measures a pair of challenges over fixed clock windows by counting synchronized oscillator edges, then compares the two counts.
- Assembles a RESP_BITS-wide response word and presents it with a done flag.
- Sits between the switch/host control logic and the puf_cro instance; replaces free-running LED display counting with a deterministic, bit-exact sequence.

Parameters:
- RESP_BITS, 8, number of response bits per run (1..32).
- WINDOW_CYCLES, 1024, clk cycles per measurement window (>=4).
- SETTLE_CYCLES, 16, clk cycles with cro_en low after each challenge change (>=1).
- CNT_W, 16, width of the edge counters (saturating).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- base_challenge  input  6  challenge base, captured on accepted start.
- ro_pulse  input  1  raw CRO output, asynchronous to clk.
- cro_challenge  output  6  challenge driven to the CRO.
- cro_en  output  1  CRO enable.
- busy  output  1  high from the cycle after accepted start until DONE is entered.
- done  output  1  one-cycle pulse when the response is valid.
- response  output  RESP_BITS  response word; held until the next accepted start.
- last_cnt_a, last_cnt_b  output  CNT_W each  counts of the most recent pair, for debug.

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE; cro_en=0; cro_challenge=0; busy=0; done=0; response=0; last_cnt_a/b=0.
- Bit index, window counters, edge counters and synchronizer flops all cleared.

Synchronizer and edge detection:
- ro_pulse passes through a 2-flop synchronizer plus a third flop for edge detect.
- A rising edge is a registered 0->1 on the synchronized signal.
- Edge counting is exact only for ro_pulse frequencies below clk/2. Faster oscillators alias; this is accepted and documented, not corrected.

Challenge pairing for bit i (0..RESP_BITS-1):
- A = base ^ (2*i)[5:0]; B = base ^ (2*i+1)[5:0].
- i is 5 bits wide; 2*i is truncated to 6 bits.

FSM states and transitions:
- IDLE: cro_en=0. On start=1, capture base, clear i and response, go to SETTLE_A.
- SETTLE_A: cro_challenge=A, cro_en=0, for SETTLE_CYCLES cycles, then MEAS_A.
  - Entering MEAS_A clears the edge counter and the synchronizer history, so no stale edge is counted.
- MEAS_A: cro_en=1, challenge held, for exactly WINDOW_CYCLES cycles.
  - Counter increments on each detected edge and saturates at 2^CNT_W-1.
  - On the last cycle, the final count, including any edge detected that cycle, is stored to last_cnt_a. Then go to SETTLE_B.
- SETTLE_B and MEAS_B: identical, using challenge B; the count goes to last_cnt_b.
- DECIDE (1 cycle): response[i] = (last_cnt_a > last_cnt_b). A tie gives 0.
  - If i == RESP_BITS-1, go to DONE; otherwise i++ and go to SETTLE_A.
- DONE (1 cycle): done=1, busy=0, then IDLE.

Timing and output rules:
- cro_en is registered and high only in MEAS_A/MEAS_B.
- cro_challenge changes only on entry to a SETTLE state, never while cro_en=1.
- Total latency from the start cycle to the done pulse = RESP_BITS*(2*(SETTLE_CYCLES+WINDOW_CYCLES)+1)+2 cycles, fixed and data-independent.
- start while busy is ignored; it is not queued.
- Asserting rst mid-run aborts immediately. cro_en drops asynchronously, the partial response is discarded, and no done pulse occurs.
- response bits update in place during a run. Consumers qualify the word with done.
- response is stable from the done pulse until the next accepted start.

Test Plan (RESP_BITS=4, WINDOW_CYCLES=16, SETTLE_CYCLES=4, CNT_W=8; bench models ro_pulse as a clk-synchronous square wave whose period depends on the current challenge):
- Reset/idle: rst high mid-clock -> all outputs 0 immediately. start never asserted -> cro_en stays 0 and done never pulses.
- Ordering: base=0, even challenges period 4, odd challenges period 8.
  - Counts 4 vs 2; response=4'b1111.
  - Sequence of cro_challenge = 0,1,2,3,4,5,6,7.
  - done pulses exactly 4*(2*20+1)+2 = 166 cycles after start.
- Reverse/XOR: base=6'h3F with the same period rule applied to the actual challenge → pairs (63,62),(61,60),(59,58),(57,56). A is always odd, so response=4'b0000.
- Tie and saturation:
  - Equal periods on A and B -> response bit 0 and last_cnt_a==last_cnt_b.
  - With CNT_W=3 and period 2 -> counter holds at 7 and never wraps.
- Protocol: start asserted again while busy -> ignored; single done pulse; cro_challenge never changes while cro_en=1 (assertion).
- Abort: rst pulsed during MEAS_B of bit 2 -> cro_en=0 and response=0 immediately. A fresh start then completes normally with correct values.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF challenge sequencer: measures each challenge pair over fixed
// windows, compares the synchronized edge counts and assembles the response word.
module puf_challenge_sequencer #(
  parameter int RESP_BITS     = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           base_challenge,
  input  logic                 ro_pulse,
  output logic [5:0]           cro_challenge,
  output logic                 cro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [CNT_W-1:0]     last_cnt_a,
  output logic [CNT_W-1:0]     last_cnt_b
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX  = 5'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE_A, MEAS_A, SETTLE_B, MEAS_B, DECIDE, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [4:0]             idx_q, idx_d;
  logic [5:0]             base_q, base_d;
  logic [2:0]             sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [5:0]             chal_q, chal_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                   tmr_done, last_bit, in_meas, ro_rise;

  assign tmr_done = (tmr_q == '0);
  assign last_bit = (idx_q == LAST_IDX);
  assign in_meas  = (state_q == MEAS_A) || (state_q == MEAS_B);
  // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the edge-detect history
  assign ro_rise  = sync_q[1] & ~sync_q[2];
  assign cnt_inc  = (ro_rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)    state_d = SETTLE_A;
      SETTLE_A: if (tmr_done) state_d = MEAS_A;
      MEAS_A:   if (tmr_done) state_d = SETTLE_B;
      SETTLE_B: if (tmr_done) state_d = MEAS_B;
      MEAS_B:   if (tmr_done) state_d = DECIDE;
      DECIDE:   state_d = last_bit ? DONE : SETTLE_A;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    idx_d   = idx_q;
    resp_d  = resp_q;
    chal_d  = chal_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    sync_d  = in_meas ? {sync_q[1:0], ro_pulse} : 3'b000;
    cnt_d   = in_meas ? cnt_inc : '0;
    tmr_d   = tmr_done ? tmr_q : tmr_q - 1'b1;
    if (state_q == IDLE && start) begin
      base_d = base_challenge;
      idx_d  = '0;
      resp_d = '0;
    end
    if (state_q == DECIDE) begin
      for (int k = 0; k < RESP_BITS; k++) begin
        if (idx_q == 5'(k)) resp_d[k] = (cnt_a_q > cnt_b_q);
      end
      if (!last_bit) idx_d = idx_q + 5'd1;
    end
    // the final window cycle includes an edge detected on that same cycle
    if (state_q == MEAS_A && tmr_done) cnt_a_d = cnt_inc;
    if (state_q == MEAS_B && tmr_done) cnt_b_d = cnt_inc;
    if (state_d != state_q) begin
      case (state_d)
        SETTLE_A, SETTLE_B: tmr_d = SETTLE_LD;
        MEAS_A, MEAS_B:     tmr_d = WIN_LD;
        default:            tmr_d = '0;
      endcase
    end
    if (state_d == SETTLE_A && state_q != SETTLE_A) chal_d = base_d ^ {idx_d, 1'b0};
    if (state_d == SETTLE_B && state_q != SETTLE_B) chal_d = base_q ^ {idx_q, 1'b1};
    en_d   = (state_d == MEAS_A) || (state_d == MEAS_B);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      sync_q  <= '0;
      cnt_q   <= '0;
      chal_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cro_challenge = chal_q;
  assign cro_en        = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign response      = resp_q;
  assign last_cnt_a    = cnt_a_q;
  assign last_cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: challenge-dependent square-wave oscillator,
// window-count reference model, directed and randomized runs.
module tb_puf_challenge_sequencer;

  localparam int RB      = 4;
  localparam int W       = 16;
  localparam int S       = 4;
  localparam int CW      = 8;
  localparam int WS      = 24;
  localparam int CWS     = 3;
  localparam int BIT_CYC = 2 * (S + W) + 1;
  localparam int LAT     = RB * BIT_CYC + 2;
  localparam int LAT_S   = RB * (2 * (S + WS) + 1) + 2;
  localparam int HIST    = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          start_s = 1'b0;
  logic          ro_pulse = 1'b0;
  logic [5:0]    base = '0;

  logic [5:0]    cro_challenge, cro_challenge_s;
  logic          cro_en, cro_en_s, busy, busy_s, done, done_s;
  logic [RB-1:0] response, response_s;
  logic [CW-1:0] last_cnt_a, last_cnt_b;
  logic [CWS-1:0] last_cnt_a_s, last_cnt_b_s;

  int errors = 0;
  int checks = 0;
  int ncnt = 0;
  int mode = 0;
  int per_tbl [64];
  bit r_hist [HIST];

  int         mon_viol = 0;
  logic       mon_prev_en = 1'b0;
  logic [5:0] mon_prev_ch = '0;

  puf_challenge_sequencer #(.RESP_BITS(RB), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_challenge(base), .ro_pulse(ro_pulse),
    .cro_challenge(cro_challenge), .cro_en(cro_en), .busy(busy), .done(done),
    .response(response), .last_cnt_a(last_cnt_a), .last_cnt_b(last_cnt_b)
  );

  puf_challenge_sequencer #(.RESP_BITS(RB), .WINDOW_CYCLES(WS), .SETTLE_CYCLES(S), .CNT_W(CWS)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .base_challenge(base), .ro_pulse(ro_pulse),
    .cro_challenge(cro_challenge_s), .cro_en(cro_en_s), .busy(busy_s), .done(done_s),
    .response(response_s), .last_cnt_a(last_cnt_a_s), .last_cnt_b(last_cnt_b_s)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input logic [5:0] ch);
    case (mode)
      0:       return ch[0] ? 8 : 4;
      1:       return per_tbl[ch];
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  // Oscillator: value driven here is sampled by the DUT at posedge number ncnt
  always @(negedge clk) begin
    int p;
    p = period_of(cro_challenge);
    ro_pulse = ((ncnt % p) < (p / 2));
    if (ncnt < HIST) r_hist[ncnt] = ro_pulse;
    ncnt = ncnt + 1;
  end

  always @(negedge clk) begin
    if (mon_prev_en && cro_en && (cro_challenge !== mon_prev_ch)) mon_viol = mon_viol + 1;
    mon_prev_en = cro_en;
    mon_prev_ch = cro_challenge;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising transitions of the sampled oscillator inside a window; the first sample
  // counts as a rise when high, and the last two samples are still in flight.
  function automatic int win_count(input int e0, input int w, input int maxv);
    int c = 0;
    for (int x = e0; x <= e0 + w - 3; x++) begin
      if (r_hist[x] && (x == e0 || !r_hist[x-1])) c++;
    end
    return (c > maxv) ? maxv : c;
  endfunction

  task automatic model_run(input int c0, input int w, input int maxv,
                           output logic [31:0] resp, output int ca, output int cb);
    int ea;
    resp = '0;
    ca = 0;
    cb = 0;
    for (int i = 0; i < RB; i++) begin
      ea = c0 + i * (2 * (S + w) + 1) + S + 1;
      ca = win_count(ea, w, maxv);
      cb = win_count(ea + S + w, w, maxv);
      if (ca > cb) resp[i] = 1'b1;
    end
  endtask

  task automatic run_main(input logic [5:0] b, input int restart_at,
                          input logic [3:0] fixed_resp, input bit use_fixed);
    int c0, t, dcnt, en_cycles, d_edge, ca, cb;
    logic [5:0] seen [$];
    logic prev_en;
    logic [31:0] er;
    tick();
    base = b;
    start = 1'b1;
    c0 = ncnt - 1;
    tick();
    start = 1'b0;
    base = 6'($urandom);
    chk("busy_run", 32'(busy), 32'd1);
    prev_en = 1'b0;
    dcnt = 0;
    en_cycles = 0;
    d_edge = -1;
    t = 1;
    while (d_edge < 0 && t < LAT + 20) begin
      start = (t == restart_at);
      if (cro_en && !prev_en) seen.push_back(cro_challenge);
      if (cro_en) en_cycles++;
      prev_en = cro_en;
      if (done) begin
        dcnt++;
        d_edge = ncnt - 2;
      end
      tick();
      t++;
    end
    start = 1'b0;
    model_run(c0, W, (1 << CW) - 1, er, ca, cb);
    chk("latency", 32'(d_edge - c0 + 1), 32'(LAT));
    chk("response", 32'(response), er);
    chk("last_cnt_a", 32'(last_cnt_a), 32'(ca));
    chk("last_cnt_b", 32'(last_cnt_b), 32'(cb));
    if (use_fixed) chk("response_fixed", 32'(response), 32'(fixed_resp));
    chk("en_cycles", 32'(en_cycles), 32'(2 * RB * W));
    chk("seq_len", 32'(seen.size()), 32'(2 * RB));
    for (int j = 0; j < seen.size() && j < 2 * RB; j++)
      chk("chal_seq", 32'(seen[j]), 32'(b ^ 6'(j)));
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("done_pulses", 32'(dcnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("resp_hold", 32'(response), er);
  endtask

  task automatic run_sat(input logic [5:0] b);
    int c0, t, d_edge, ca, cb;
    logic [31:0] er;
    tick();
    base = b;
    start_s = 1'b1;
    c0 = ncnt - 1;
    tick();
    start_s = 1'b0;
    chk("sat_busy", 32'(busy_s), 32'd1);
    d_edge = -1;
    t = 1;
    while (d_edge < 0 && t < LAT_S + 20) begin
      if (done_s) d_edge = ncnt - 2;
      tick();
      t++;
    end
    model_run(c0, WS, (1 << CWS) - 1, er, ca, cb);
    chk("sat_latency", 32'(d_edge - c0 + 1), 32'(LAT_S));
    chk("sat_response", 32'(response_s), er);
    chk("sat_cnt_a", 32'(last_cnt_a_s), 32'(ca));
    chk("sat_cnt_b", 32'(last_cnt_b_s), 32'(cb));
    chk("sat_hold_max", 32'(last_cnt_a_s), 32'd7);
    chk("sat_last_chal", 32'(cro_challenge_s), 32'(b ^ 6'd7));
    chk("sat_en_off", 32'(cro_en_s), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, guard, dcnt, en_seen;
    for (int i = 0; i < 64; i++) per_tbl[i] = int'($urandom_range(2, 9));

    // Asynchronous reset raised mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("rst_en", 32'(cro_en), 32'd0);
    chk("rst_chal", 32'(cro_challenge), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(response), 32'd0);
    chk("rst_cnt_a", 32'(last_cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(last_cnt_b), 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    dcnt = 0;
    en_seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) dcnt++;
      if (cro_en) en_seen++;
    end
    chk("idle_en", 32'(en_seen), 32'd0);
    chk("idle_done", 32'(dcnt), 32'd0);

    mode = 0;
    run_main(6'h00, 0, 4'b1111, 1'b1);
    run_main(6'h3F, 0, 4'b0000, 1'b1);
    mode = 2;
    run_main(6'($urandom), 0, 4'b0000, 1'b1);
    mode = 1;
    for (int r = 0; r < 3; r++) run_main(6'($urandom), 0, 4'b0000, 1'b0);
    mode = 0;
    run_main(6'h10, 10, 4'b1111, 1'b1);

    // Abort during the MEAS_B window of bit 2
    tick();
    base = 6'h00;
    start = 1'b1;
    c0 = ncnt - 1;
    tick();
    start = 1'b0;
    guard = 0;
    while (ncnt - 2 < c0 + 2 * BIT_CYC + 2 * S + W + 4 && guard < 400) begin
      tick();
      guard++;
    end
    chk("abort_pre_en", 32'(cro_en), 32'd1);
    chk("abort_pre_resp", 32'(response), 32'b0011);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_en", 32'(cro_en), 32'd0);
    chk("abort_resp", 32'(response), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_chal", 32'(cro_challenge), 32'd0);
    dcnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_main(6'h00, 0, 4'b1111, 1'b1);

    mode = 3;
    run_sat(6'($urandom));

    chk("en_chal_hold", 32'(mon_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
